// File: rtl/maze_pkg.sv
// -----------------------------------------------------------------------------
// maze_pkg
// Shared definitions for the maze controller and its move checker:
//   - controller state encoding and move direction codes
//   - ROM address map (rows, start point, end point)
//   - packed point type and the ROM-byte -> point decoder
// -----------------------------------------------------------------------------
package maze_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_WON  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,   // row - 1
        DIR_DOWN  = 2'd1,   // row + 1
        DIR_LEFT  = 2'd2,   // col - 1
        DIR_RIGHT = 2'd3    // col + 1
    } dir_t;

    // ROM layout: eight map rows, then the start point, then the end point.
    localparam int ROW_BASE   = 0;
    localparam int START_ADDR = 8;
    localparam int END_ADDR   = 9;
    localparam int MAP_ROWS   = 8;

    // Point byte layout: [5:3] row, [2:0] col, [7:6] unused.
    localparam int PT_ROW_LSB = 3;
    localparam int PT_COL_LSB = 0;

    // {row, col} packed: the 6-bit value equals 8*row + col, so the map bit
    // of a cell (bit 63 - 8*row - col) is simply map[~point].
    typedef struct packed {
        logic [2:0] row;
        logic [2:0] col;
    } point_t;

    function automatic point_t decode_point(input logic [5:0] d);
        point_t p;
        p.row = d[PT_ROW_LSB +: 3];
        p.col = d[PT_COL_LSB +: 3];
        return p;
    endfunction

endpackage

// File: rtl/maze_ctrl_if.sv
// -----------------------------------------------------------------------------
// maze_ctrl_if
// Bundles every non-clock signal of the maze controller.
//   slave  : the controller itself (drives ROM enable/address, move results,
//            map and status)
//   master : its environment (game logic issuing load/moves, plus the ROM
//            returning rom_data)
// -----------------------------------------------------------------------------
interface maze_ctrl_if #(
    parameter int STEP_W = 8,
    parameter int ROM_AW = 4
);
    logic              load;
    logic              rom_en;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              move_valid;
    logic [1:0]        move_dir;
    logic              move_ready;
    logic              move_ok;
    logic              move_err;
    logic [63:0]       map;
    logic [2:0]        pos_row;
    logic [2:0]        pos_col;
    logic [2:0]        end_row;
    logic [2:0]        end_col;
    logic              loaded;
    logic              win;
    logic              start_err;
    logic [STEP_W-1:0] steps;

    modport slave (
        input  load, rom_data, move_valid, move_dir,
        output rom_en, rom_addr, move_ready, move_ok, move_err, map,
               pos_row, pos_col, end_row, end_col, loaded, win, start_err, steps
    );

    modport master (
        output load, rom_data, move_valid, move_dir,
        input  rom_en, rom_addr, move_ready, move_ok, move_err, map,
               pos_row, pos_col, end_row, end_col, loaded, win, start_err, steps
    );
endinterface

// File: rtl/maze_move_chk.sv
// -----------------------------------------------------------------------------
// maze_move_chk
// Purely combinational legality check for one move on an 8x8 map.
//   pos_i   : current cell
//   dir_i   : direction code (dir_t)
//   map_i   : cell map, bit [63-8*r-c] = cell (r,c), 1 = open
//   tgt_o   : neighbouring cell in that direction (equals pos_i when the
//             move would leave the board)
//   legal_o : target is on the board and open
// -----------------------------------------------------------------------------
module maze_move_chk
    import maze_pkg::*;
(
    input  point_t      pos_i,
    input  logic [1:0]  dir_i,
    input  logic [63:0] map_i,
    output point_t      tgt_o,
    output logic        legal_o
);

    logic       in_bounds;
    logic [5:0] tgt_idx;

    always_comb begin
        tgt_o     = pos_i;
        in_bounds = 1'b1;
        case (dir_i)
            DIR_UP: begin
                if (pos_i.row == 3'd0) in_bounds = 1'b0;
                else                   tgt_o.row = pos_i.row - 3'd1;
            end
            DIR_DOWN: begin
                if (pos_i.row == 3'd7) in_bounds = 1'b0;
                else                   tgt_o.row = pos_i.row + 3'd1;
            end
            DIR_LEFT: begin
                if (pos_i.col == 3'd0) in_bounds = 1'b0;
                else                   tgt_o.col = pos_i.col - 3'd1;
            end
            default: begin
                if (pos_i.col == 3'd7) in_bounds = 1'b0;
                else                   tgt_o.col = pos_i.col + 3'd1;
            end
        endcase
    end

    assign tgt_idx = ~tgt_o;
    assign legal_o = in_bounds && map_i[tgt_idx];

endmodule

// File: rtl/maze_ctrl.sv
// -----------------------------------------------------------------------------
// maze_ctrl
// Loads an 8x8 maze (plus start/end points) from a registered-read ROM and
// then runs the player-move engine.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : maze_ctrl_if.slave
//           load        restart a map load from any state
//           rom_en/addr ROM read port (data returns one cycle later)
//           move_*      direction request / ready / ok-err result pulses
//           map, pos_*, end_*, loaded, win, start_err, steps  status
// Load sequence: the load edge clears cnt; on each following edge cnt
// increments and, from cnt=1, the byte returned for address cnt-1 is stored.
// The edge at cnt=10 stores the end point and picks IDLE/PLAY/WON.
// -----------------------------------------------------------------------------
module maze_ctrl
    import maze_pkg::*;
#(
    parameter int STEP_W = 8,
    parameter int ROM_AW = 4
)(
    input  logic        clk,
    input  logic        rst_n,
    maze_ctrl_if.slave  bus
);

    state_t            state_q;
    logic [ROM_AW-1:0] cnt_q;
    logic [63:0]       map_q;
    point_t            pos_q;
    point_t            end_q;
    point_t            start_q;
    logic [STEP_W-1:0] steps_q;
    logic              start_err_q;
    logic              move_ok_q;
    logic              move_err_q;

    point_t            rom_pt;
    point_t            tgt;
    logic              legal;
    logic [5:0]        start_idx;
    logic [MAP_ROWS-1:0] row_we;

    assign rom_pt    = decode_point(bus.rom_data[5:0]);
    assign start_idx = ~start_q;

    // Row r's byte arrives while cnt = ROW_BASE + r + 1.
    for (genvar gi = 0; gi < MAP_ROWS; gi++) begin : g_row_we
        assign row_we[gi] = (state_q == ST_LOAD) &&
                            (cnt_q == ROM_AW'(ROW_BASE + gi + 1));
    end

    maze_move_chk u_move_chk (
        .pos_i   (pos_q),
        .dir_i   (bus.move_dir),
        .map_i   (map_q),
        .tgt_o   (tgt),
        .legal_o (legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            map_q       <= '0;
            pos_q       <= '0;
            end_q       <= '0;
            start_q     <= '0;
            steps_q     <= '0;
            start_err_q <= 1'b0;
            move_ok_q   <= 1'b0;
            move_err_q  <= 1'b0;
        end else begin
            move_ok_q  <= 1'b0;
            move_err_q <= 1'b0;
            if (bus.load) begin
                // Load wins over any same-cycle move; no result pulse follows.
                state_q     <= ST_LOAD;
                cnt_q       <= '0;
                map_q       <= '0;
                steps_q     <= '0;
                start_err_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_LOAD: begin
                        cnt_q <= cnt_q + 1'b1;
                        for (int r = 0; r < MAP_ROWS; r++) begin
                            if (row_we[r]) map_q[(7-r)*8 +: 8] <= bus.rom_data;
                        end
                        if (cnt_q == ROM_AW'(START_ADDR + 1)) begin
                            start_q <= rom_pt;
                        end
                        if (cnt_q == ROM_AW'(END_ADDR + 1)) begin
                            pos_q   <= start_q;
                            end_q   <= rom_pt;
                            steps_q <= '0;
                            if (!map_q[start_idx]) begin
                                state_q     <= ST_IDLE;
                                start_err_q <= 1'b1;
                            end else if (start_q == rom_pt) begin
                                state_q <= ST_WON;
                            end else begin
                                state_q <= ST_PLAY;
                            end
                        end
                    end
                    ST_PLAY: begin
                        if (bus.move_valid) begin
                            if (legal) begin
                                pos_q     <= tgt;
                                move_ok_q <= 1'b1;
                                if (steps_q != '1) steps_q <= steps_q + 1'b1;
                                if (tgt == end_q) state_q <= ST_WON;
                            end else begin
                                move_err_q <= 1'b1;
                            end
                        end
                    end
                    default: ;  // IDLE and WON hold until the next load
                endcase
            end
        end
    end

    assign bus.rom_en     = (state_q == ST_LOAD) && (cnt_q <= ROM_AW'(END_ADDR));
    assign bus.rom_addr   = (state_q == ST_LOAD) ? cnt_q : '0;
    assign bus.move_ready = (state_q == ST_PLAY);
    assign bus.move_ok    = move_ok_q;
    assign bus.move_err   = move_err_q;
    assign bus.map        = map_q;
    assign bus.pos_row    = pos_q.row;
    assign bus.pos_col    = pos_q.col;
    assign bus.end_row    = end_q.row;
    assign bus.end_col    = end_q.col;
    assign bus.loaded     = (state_q == ST_PLAY) || (state_q == ST_WON);
    assign bus.win        = (state_q == ST_WON);
    assign bus.start_err  = start_err_q;
    assign bus.steps      = steps_q;

endmodule
